// File: rtl/tmr_vote_mon.sv
// Triple-modular-redundancy voter with per-replica health monitoring and mode degradation.
// Optional corrected-error counter is built only when TMR_ERR_CNT_EN is defined.
module tmr_vote_mon #(
    parameter int unsigned REG_WIDTH    = 8,
    parameter int unsigned FAULT_THRESH = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [REG_WIDTH-1:0] din_r1,
    input  logic [REG_WIDTH-1:0] din_r2,
    input  logic [REG_WIDTH-1:0] din_r3,
    input  logic                 clr_fault,
    output logic [REG_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic [2:0]           mismatch,
    output logic [2:0]           lane_fail,
    output logic                 uncorr,
    output logic                 fatal,
    output logic [1:0]           mode,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam int unsigned SW = $clog2(FAULT_THRESH + 1);

    typedef enum logic [1:0] {
        MODE_NORM = 2'd0,
        MODE_DEGR = 2'd1,
        MODE_FAIL = 2'd2
    } mode_t;

    mode_t state, state_nxt;

    logic                 a_valid;
    logic [REG_WIDTH-1:0] a_r1, a_r2, a_r3;
    logic [REG_WIDTH-1:0] vote;
    logic [2:0][SW-1:0]   streak, streak_nxt;

    logic [REG_WIDTH-1:0] dout_nxt;
    logic [2:0]           mismatch_nxt;
    logic [2:0]           lane_fail_nxt;
    logic                 uncorr_nxt;
    logic [REG_WIDTH-1:0] hw0, hw1;
    logic [2:0]           hmask;
    logic [1:0]           nfail;

    assign vote = (a_r1 & a_r2) | (a_r1 & a_r3) | (a_r2 & a_r3);
    assign mode = state;

    // Healthy pair used for the 2-of-2 compare once one lane is retired
    always_comb begin
        hw0   = a_r1;
        hw1   = a_r2;
        hmask = 3'b011;
        if (lane_fail[0]) begin
            hw0   = a_r2;
            hw1   = a_r3;
            hmask = 3'b110;
        end else if (lane_fail[1]) begin
            hw0   = a_r1;
            hw1   = a_r3;
            hmask = 3'b101;
        end
    end

    // Next-state and output evaluation; clr_fault overrides all health bookkeeping
    always_comb begin
        state_nxt     = state;
        dout_nxt      = dout;
        mismatch_nxt  = mismatch;
        lane_fail_nxt = lane_fail;
        uncorr_nxt    = 1'b0;
        streak_nxt    = streak;
        nfail         = 2'd0;

        if (clr_fault) begin
            state_nxt     = MODE_NORM;
            lane_fail_nxt = 3'b000;
            streak_nxt    = '0;
            if (a_valid) begin
                dout_nxt = vote;
            end
        end else if (a_valid) begin
            case (state)
                MODE_NORM: begin
                    dout_nxt     = vote;
                    mismatch_nxt = {a_r3 != vote, a_r2 != vote, a_r1 != vote};
                end
                MODE_DEGR: begin
                    if (hw0 == hw1) begin
                        dout_nxt     = hw0;
                        mismatch_nxt = 3'b000;
                    end else begin
                        uncorr_nxt   = 1'b1;
                        mismatch_nxt = hmask;
                    end
                end
                default: begin
                    mismatch_nxt = 3'b000;
                end
            endcase

            for (int k = 0; k < 3; k++) begin
                if (!lane_fail[k]) begin
                    if (mismatch_nxt[k]) begin
                        streak_nxt[k] = streak[k] + SW'(1);
                        if (streak[k] == SW'(FAULT_THRESH - 1)) begin
                            lane_fail_nxt[k] = 1'b1;
                        end
                    end else begin
                        streak_nxt[k] = '0;
                    end
                end
            end

            nfail = {1'b0, lane_fail_nxt[0]} + {1'b0, lane_fail_nxt[1]} + {1'b0, lane_fail_nxt[2]};
            case (nfail)
                2'd0:    state_nxt = MODE_NORM;
                2'd1:    state_nxt = MODE_DEGR;
                default: state_nxt = MODE_FAIL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid    <= 1'b0;
            a_r1       <= '0;
            a_r2       <= '0;
            a_r3       <= '0;
            state      <= MODE_NORM;
            streak     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            mismatch   <= 3'b000;
            lane_fail  <= 3'b000;
            uncorr     <= 1'b0;
            fatal      <= 1'b0;
        end else begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_r1 <= din_r1;
                a_r2 <= din_r2;
                a_r3 <= din_r3;
            end
            state      <= state_nxt;
            streak     <= streak_nxt;
            dout       <= dout_nxt;
            dout_valid <= a_valid;
            mismatch   <= mismatch_nxt;
            lane_fail  <= lane_fail_nxt;
            uncorr     <= uncorr_nxt;
            fatal      <= (state_nxt == MODE_FAIL);
        end
    end

`ifdef TMR_ERR_CNT_EN
    logic                 cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Only NORM-mode corrections are counted; counter sticks at all-ones
    assign cnt_inc = a_valid && !clr_fault && (state == MODE_NORM) && (|mismatch_nxt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_fault) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/tmr_vote_mon.md
# tmr_vote_mon

Parametrised triple-modular-redundancy voter with per-replica health monitoring. It registers three redundant copies of a REG_WIDTH status/data word and produces a registered bitwise majority vote. It also detects which replica disagrees, retires replicas that disagree persistently, and degrades the voting mode as replicas are retired. It sits at the boundary between triplicated logic and single-string consumers, and replaces the plain fixed 2-of-3 voter wherever fault visibility is required.

## Interface
- REG_WIDTH, 8, width of each replica word and of the voted output
- FAULT_THRESH, 4, consecutive mismatching samples that retire a replica; legal range 1..255
- CNT_WIDTH, 16, width of the saturating corrected-error counter
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- in_valid  in  1  replica words are valid this cycle
- din_r1 / din_r2 / din_r3  in  REG_WIDTH  replica words 1..3
- clr_fault  in  1  single-cycle pulse; clears retirements, streak counters and err_cnt
- dout  out  REG_WIDTH  voted word
- dout_valid  out  1  dout updated this cycle
- mismatch  out  3  per-replica disagreement for the current output sample
- lane_fail  out  3  sticky per-replica retired flags
- uncorr  out  1  pulse: healthy replicas disagreed and the sample could not be voted
- fatal  out  1  level: fewer than two healthy replicas
- mode  out  2  0 NORM, 1 DEGR, 2 FAIL
- err_cnt  out  CNT_WIDTH  saturating count of corrected samples

## Operation
- Stage A: when in_valid=1, register the three words and set a_valid. Otherwise a_valid=0 and the words hold.
- Stage B: on each a_valid, evaluate the registered words according to mode.
- NORM (no replica retired):
  - dout = (r1&r2)|(r1&r3)|(r2&r3).
  - mismatch[k] = (rk != dout).
  - If any mismatch bit is set, err_cnt increments.
- DEGR (exactly one replica retired):
  - If the two healthy words are equal, dout takes that value.
  - Otherwise dout holds its previous value, uncorr pulses, and both healthy lanes flag mismatch.
  - The retired lane's mismatch bit is always 0.
- FAIL (two or more replicas retired):
  - dout holds, fatal=1, and dout_valid still pulses.
  - mismatch = 0 and uncorr = 0.
- Streak counter per lane (width clog2(FAULT_THRESH+1)):
  - On a_valid, +1 if mismatch[k], cleared to 0 otherwise.
  - On reaching FAULT_THRESH, lane_fail[k] sets and the counter freezes.
- Mode transitions are evaluated on the same edge that updates lane_fail:
  - popcount(lane_fail) = 0 → NORM; 1 → DEGR; ≥2 → FAIL.
  - Two lanes crossing the threshold on the same sample go NORM → FAIL directly.
- clr_fault has priority over sample evaluation:
  - It clears lane_fail, all streak counters and err_cnt, and sets mode to NORM.
  - A sample in stage B in that cycle still produces dout/dout_valid, voted as NORM, but updates no counters, lane_fail, mismatch or uncorr.
- err_cnt saturates at all-ones and never wraps.

## Timing
- Latency: in_valid sampled at edge 0 → dout/dout_valid/mismatch/uncorr valid after edge 1. Full throughput: one sample per cycle.
- dout_valid, uncorr: single-cycle pulses per sample. mismatch holds until the next sample.
- lane_fail/mode/fatal change on the same edge as the mismatch output that triggered them.
- Reset values: dout=0, dout_valid=0, mismatch=0, lane_fail=0, uncorr=0, fatal=0, mode=NORM, err_cnt=0, a_valid=0, streaks=0.
- Reset mid-operation: an in-flight stage A sample is discarded and produces no output.

## Configuration
- TMR_ERR_CNT_EN defined: err_cnt is implemented as described.
- TMR_ERR_CNT_EN undefined: no counter register is built, err_cnt is tied to 0, and all other behaviour is unchanged.

## Test plan
- All replicas 8'hA5 for 10 samples → dout=8'hA5 two cycles after each in_valid, mismatch=0, err_cnt=0.
- r2=8'h5A, r1=r3=8'hA5 for one sample → dout=8'hA5, mismatch=3'b010, err_cnt=1, lane_fail=0.
- r3 corrupted for 4 consecutive samples (FAULT_THRESH=4) → lane_fail=3'b100 and mode=DEGR on the 4th output. Next sample r1=8'h01, r2=8'h02 → uncorr pulse, dout holds 8'hA5.
- r1 and r2 each disagreeing in different bits for 4 consecutive samples → both lane_fail bits set, mode goes NORM → FAIL in one step, fatal=1, dout holds.
- clr_fault in FAIL while a sample is in stage B → mode=NORM, lane_fail=0, err_cnt=0, dout_valid pulses with the NORM vote.
- err_cnt preloaded near saturation (CNT_WIDTH=4) with 20 single-lane errors → err_cnt stops at 4'hF. With TMR_ERR_CNT_EN undefined, err_cnt stays 0.
